// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/LOAD/EXEC sequencer that drives the 8-bit datapath controls.
// Ports: clock/resetN (async active-low); imemAddr/imemData to the synchronous instruction ROM;
// rx/ry/selOp/destSrc/regWrite to the datapath; inValid/inReady and outValid/outReady handshake
// the IN/OUT ports; halted flags the terminal HALT state.
module control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clock,
    input  logic            resetN,
    output logic [PC_W-1:0] imemAddr,
    input  logic [15:0]     imemData,
    output logic [2:0]      rx,
    output logic [2:0]      ry,
    output logic [2:0]      selOp,
    output logic [1:0]      destSrc,
    output logic            regWrite,
    input  logic            inValid,
    output logic            inReady,
    output logic            outValid,
    input  logic            outReady,
    output logic            halted
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_IN   = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h5;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0] op;
    logic       exec, is_mov, is_in, is_out, is_alu;

    assign op     = ir_q[15:12];
    assign exec   = state_q == EXEC;
    assign is_mov = op == OP_MOV;
    assign is_in  = op == OP_IN;
    assign is_out = op == OP_OUT;
    assign is_alu = op[3];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: state_d = LOAD;
            LOAD: begin
                ir_d    = imemData;
                pc_d    = pc_q + PC_W'(1);
                state_d = EXEC;
            end
            EXEC: begin
                // JMP overrides the increment already applied in LOAD
                if (op == OP_JMP) pc_d = ir_q[PC_W-1:0];
                state_d = (op == OP_HALT) ? HALTED :
                          ((is_in && !inValid) || (is_out && !outReady)) ? EXEC : FETCH;
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imemAddr = pc_q;
    assign rx       = ir_q[11:9];
    assign ry       = ir_q[8:6];
    assign selOp    = (exec && is_alu) ? op[2:0] : 3'd0;
    assign destSrc  = !exec ? 2'd0 : is_mov ? 2'd1 : is_out ? 2'd3 : is_alu ? 2'd2 : 2'd0;
    // IN writes only in the cycle its byte is present, so the write and the consume coincide
    assign regWrite = exec && (is_mov || is_alu || (is_in && inValid));
    assign inReady  = exec && is_in && inValid;
    assign outValid = exec && is_out;
    assign halted   = state_q == HALTED;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven, scoreboarded cycle checks of control_unit with a synchronous ROM model.
module tb_control_unit;
    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] sel;
        logic [1:0] dsrc;
        logic       rw;
        logic       ird;
        logic       ov;
        logic       hlt;
    } out_t;

    typedef struct {
        logic iv;
        logic ordy;
        out_t exp;
    } vec_t;

    logic        clock = 0;
    logic        resetN = 0;
    logic [7:0]  imemAddr;
    logic [15:0] imemData;
    logic [2:0]  rx, ry, selOp;
    logic [1:0]  destSrc;
    logic        regWrite, inValid = 0, inReady, outValid, outReady = 0, halted;

    logic [15:0] rom [256];
    vec_t        tbl [$];
    out_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    control_unit #(.PC_W(8)) dut (
        .clock(clock), .resetN(resetN), .imemAddr(imemAddr), .imemData(imemData),
        .rx(rx), .ry(ry), .selOp(selOp), .destSrc(destSrc), .regWrite(regWrite),
        .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
        .halted(halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imemData <= rom[imemAddr];

    function automatic out_t cur();
        return '{imemAddr, rx, ry, selOp, destSrc, regWrite, inReady, outValid, halted};
    endfunction

    function automatic vec_t v(input logic iv, input logic ordy, input logic [7:0] a,
                               input logic [2:0] x, input logic [2:0] y, input logic [2:0] s,
                               input logic [1:0] d, input logic w, input logic r,
                               input logic o, input logic h);
        vec_t t;
        t.iv   = iv;
        t.ordy = ordy;
        t.exp  = '{a, x, y, s, d, w, r, o, h};
        return t;
    endfunction

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got addr=%h rx=%0d ry=%0d sel=%0d dsrc=%0d rw=%b ird=%b ov=%b hlt=%b, want addr=%h rx=%0d ry=%0d sel=%0d dsrc=%0d rw=%b ird=%b ov=%b hlt=%b",
                     nm, got.addr, got.rx, got.ry, got.sel, got.dsrc, got.rw, got.ird, got.ov, got.hlt,
                     exp.addr, exp.rx, exp.ry, exp.sel, exp.dsrc, exp.rw, exp.ird, exp.ov, exp.hlt);
        end
    endtask

    // assert reset at posedge+1 and clear the ROM while it is held
    task automatic begin_test();
        @(posedge clock);
        #1;
        resetN   = 0;
        inValid  = 0;
        outReady = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        tbl.delete();
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        resetN = 1;
    endtask

    // starts at posedge+1; each entry is one clock cycle, sampled at the falling edge
    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            inValid  = tbl[i].iv;
            outReady = tbl[i].ordy;
            sb.push_back(tbl[i].exp);
            @(negedge clock);
            check($sformatf("%s[%0d]", nm, i), cur(), sb.pop_front());
            @(posedge clock);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        #3;
        check("reset_state", cur(), '0);

        // NOP / JMP 0 loop: fetch addresses 0,1,0,1 at a 3-cycle period, never a write
        begin_test();
        rom[0] = 16'h0000;
        rom[1] = 16'h4000;
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
            tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
            tbl.push_back(v(0,0,8'h01,0,0,0,0,0,0,0,0));
            tbl.push_back(v(0,0,8'h01,0,0,0,0,0,0,0,0));
            tbl.push_back(v(0,0,8'h01,0,0,0,0,0,0,0,0));
            tbl.push_back(v(0,0,8'h02,0,0,0,0,0,0,0,0));
        end
        release_reset();
        run_table("nop_jmp");

        // ALU 0xA4C0, MOV R6<-R1, HALT; then reset pulse restarts from 0
        begin_test();
        rom[0] = 16'hA4C0;
        rom[1] = 16'h1C40;
        rom[2] = 16'h5000;
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,2,3,2,2,1,0,0,0));
        tbl.push_back(v(0,0,8'h01,2,3,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,2,3,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h02,6,1,0,1,1,0,0,0));
        tbl.push_back(v(0,0,8'h02,6,1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h02,6,1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h03,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,8'h03,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,8'h03,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,8'h03,0,0,0,0,0,0,0,1));
        release_reset();
        run_table("alu_mov_halt");
        resetN = 0;
        #1;
        check("halt_reset", cur(), '0);
        @(posedge clock);
        #1;
        resetN = 1;
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,2,3,2,2,1,0,0,0));
        run_table("halt_restart");

        // IN R5 waits 4 cycles, then IN R5 with data already present, then HALT
        begin_test();
        rom[0] = 16'h2A00;
        rom[1] = 16'h2A00;
        rom[2] = 16'h5000;
        tbl.push_back(v(1,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,8'h00,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++) tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,8'h01,5,0,0,0,1,1,0,0));
        tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,8'h02,5,0,0,0,1,1,0,0));
        tbl.push_back(v(0,0,8'h02,5,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h02,5,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h03,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h03,0,0,0,0,0,0,0,1));
        release_reset();
        run_table("in_wait");

        // OUT R1 with outReady low for 2 EXEC cycles; outReady high outside EXEC is ignored
        begin_test();
        rom[0] = 16'h3200;
        rom[1] = 16'h5000;
        tbl.push_back(v(0,1,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,1,0,0,3,0,0,1,0));
        tbl.push_back(v(0,0,8'h01,1,0,0,3,0,0,1,0));
        tbl.push_back(v(0,1,8'h01,1,0,0,3,0,0,1,0));
        tbl.push_back(v(0,1,8'h01,1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h02,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h02,0,0,0,0,0,0,0,1));
        release_reset();
        run_table("out_wait");

        // JMP 0xFE, NOPs at 0xFE/0xFF, PC wraps to 0x00 and re-executes the JMP
        begin_test();
        rom[0] = 16'h40FE;
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,0,3,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'hFE,0,3,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'hFE,0,3,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'hFF,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'hFF,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'hFF,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,0,3,0,0,0,0,0,0));
        release_reset();
        run_table("pc_wrap");

        // reset in the middle of an IN wait drops the write and restarts at 0
        begin_test();
        rom[0] = 16'h2A00;
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        release_reset();
        run_table("in_pre_reset");
        inValid = 1;
        #1;
        check("in_armed", cur(), '{8'h01, 3'd5, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        resetN = 0;
        #1;
        check("in_reset_now", cur(), '0);
        @(posedge clock);
        #1;
        check("in_reset_held", cur(), '0);
        inValid = 0;
        resetN  = 1;
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h00,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,8'h01,5,0,0,0,0,0,0,0));
        run_table("in_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
